// File: rtl/cache_arbiter_pkg.sv
// Shared types for the LC-3b cache/memory arbitration path (package lc3b_types).
package lc3b_types;

  localparam int LINE_BITS = 128;

  typedef logic [LINE_BITS-1:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } arb_grant_t;

endpackage

// File: rtl/cache_arbiter_control.sv
// Grant sequencing for the shared memory port: state register, last_grant
// history and tie-break. Emits registered one-hot serve selects.
// Optional feature: ARB_RR_EN selects round-robin tie-break instead of
// fixed D-cache priority.
module arbiter_control
  import lc3b_types::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_req,
  input  logic d_req,
  input  logic mem_resp,
  output logic serve_i,
  output logic serve_d
);

  arb_state_t state_q;
  arb_grant_t last_grant_q;
  arb_grant_t tie_pick;

`ifdef ARB_RR_EN
  // Tie-break: hand the port to whichever cache did not get it last time.
  always_comb begin
    tie_pick = (last_grant_q == GRANT_I) ? GRANT_D : GRANT_I;
  end
`else
  // Tie-break: the D-cache miss belongs to the older instruction, so it wins.
  always_comb begin
    tie_pick = GRANT_D;
  end

  // History is still tracked but nothing consumes it in fixed-priority mode.
  logic unused_last_grant;
  assign unused_last_grant = (last_grant_q == GRANT_D);
`endif

  // Grant FSM: pick a requester from IDLE, hold the grant until memory completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
      serve_i      <= 1'b0;
      serve_d      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (d_req && (!i_req || tie_pick == GRANT_D)) begin
            state_q      <= SERVE_D;
            last_grant_q <= GRANT_D;
            serve_d      <= 1'b1;
          end else if (i_req) begin
            state_q      <= SERVE_I;
            last_grant_q <= GRANT_I;
            serve_i      <= 1'b1;
          end
        end
        SERVE_I, SERVE_D: begin
          if (mem_resp) begin
            state_q <= IDLE;
            serve_i <= 1'b0;
            serve_d <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          serve_i <= 1'b0;
          serve_d <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one physical-memory port between the I-cache and D-cache miss paths.
// Forwarded request and routed response are combinational from the grant.
// Optional feature: ARB_RR_EN (round-robin tie-break, see arbiter_control).
module cache_arbiter #(
  parameter int LINE_BITS   = 128,
  parameter int OFFSET_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 icache_pmem_read,
  input  logic [15:0]          icache_pmem_address,
  output logic [LINE_BITS-1:0] icache_pmem_rdata,
  output logic                 icache_pmem_resp,
  input  logic                 dcache_pmem_read,
  input  logic                 dcache_pmem_write,
  input  logic [15:0]          dcache_pmem_address,
  input  logic [LINE_BITS-1:0] dcache_pmem_wdata,
  output logic [LINE_BITS-1:0] dcache_pmem_rdata,
  output logic                 dcache_pmem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [15:0]          pmem_address,
  output logic [LINE_BITS-1:0] pmem_wdata,
  input  logic [LINE_BITS-1:0] pmem_rdata,
  input  logic                 pmem_resp
);

  // Line-aligns forwarded addresses.
  localparam logic [15:0] ADDR_MASK = 16'hFFFF << OFFSET_BITS;

  logic serve_i;
  logic serve_d;

  arbiter_control u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .i_req    (icache_pmem_read),
    .d_req    (dcache_pmem_read | dcache_pmem_write),
    .mem_resp (pmem_resp),
    .serve_i  (serve_i),
    .serve_d  (serve_d)
  );

  // Fill data goes to both caches; each only trusts it alongside its own resp.
  assign icache_pmem_rdata = pmem_rdata;
  assign dcache_pmem_rdata = pmem_rdata;
  assign pmem_wdata        = dcache_pmem_wdata;

  // Forward the granted requester's command and route the completion back to it.
  always_comb begin
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    pmem_address     = dcache_pmem_address & ADDR_MASK;
    icache_pmem_resp = 1'b0;
    dcache_pmem_resp = 1'b0;
    if (serve_i) begin
      pmem_read        = icache_pmem_read;
      pmem_address     = icache_pmem_address & ADDR_MASK;
      icache_pmem_resp = pmem_resp;
    end else if (serve_d) begin
      // A writeback outranks a fill if the D-cache raises both.
      pmem_write       = dcache_pmem_write;
      pmem_read        = dcache_pmem_read & ~dcache_pmem_write;
      dcache_pmem_resp = pmem_resp;
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios with literal expectations plus
// randomized cache/memory agents checked every cycle against a rule model.
module tb_cache_arbiter;

  localparam int LB = 128;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          ireq;
  logic [15:0]   iaddr;
  logic [LB-1:0] irdata;
  logic          iresp;
  logic          dr, dw;
  logic [15:0]   daddr;
  logic [LB-1:0] dwdata;
  logic [LB-1:0] drdata;
  logic          dresp;
  logic          pread, pwrite;
  logic [15:0]   paddr;
  logic [LB-1:0] pwdata;
  logic [LB-1:0] prdata;
  logic          presp;

  always #5 clk = ~clk;

  cache_arbiter #(.LINE_BITS(LB), .OFFSET_BITS(4)) dut (
    .clk                 (clk),
    .reset               (reset),
    .icache_pmem_read    (ireq),
    .icache_pmem_address (iaddr),
    .icache_pmem_rdata   (irdata),
    .icache_pmem_resp    (iresp),
    .dcache_pmem_read    (dr),
    .dcache_pmem_write   (dw),
    .dcache_pmem_address (daddr),
    .dcache_pmem_wdata   (dwdata),
    .dcache_pmem_rdata   (drdata),
    .dcache_pmem_resp    (dresp),
    .pmem_read           (pread),
    .pmem_write          (pwrite),
    .pmem_address        (paddr),
    .pmem_wdata          (pwdata),
    .pmem_rdata          (prdata),
    .pmem_resp           (presp)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: who holds the port (0 none, 1 I-cache, 2 D-cache) and who had it last.
  int owner = 0;
  int last  = 1;
  bit want_d;
  bit pick_d;

  always @(posedge clk) begin
    if (reset) begin
      owner = 0;
      last  = 1;
    end else if (owner == 0) begin
      want_d = dr | dw;
      if (want_d && ireq) pick_d = RR ? (last == 1) : 1'b1;
      else                pick_d = want_d;
      if (pick_d)    begin owner = 2; last = 2; end
      else if (ireq) begin owner = 1; last = 1; end
    end else if (presp) begin
      owner = 0;
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      if (owner == 1) begin
        check("m_rd",    pread,  ireq);
        check("m_wr",    pwrite, 1'b0);
        check("m_addr",  paddr,  iaddr & 16'hFFF0);
        check("m_iresp", iresp,  presp);
        check("m_dresp", dresp,  1'b0);
        if (presp) check("m_irdata", irdata, prdata);
      end else if (owner == 2) begin
        check("m_rd",    pread,  dr & ~dw);
        check("m_wr",    pwrite, dw);
        check("m_addr",  paddr,  daddr & 16'hFFF0);
        check("m_wdata", pwdata, dwdata);
        check("m_iresp", iresp,  1'b0);
        check("m_dresp", dresp,  presp);
        if (presp) check("m_drdata", drdata, prdata);
      end else begin
        check("m_rd",    pread,  1'b0);
        check("m_wr",    pwrite, 1'b0);
        check("m_iresp", iresp,  1'b0);
        check("m_dresp", dresp,  1'b0);
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  logic [LB-1:0] line_v;
  bit            i_got, d_got;
  int            kind;

  initial begin
    reset = 1'b1; ireq = 1'b0; iaddr = '0; dr = 1'b0; dw = 1'b0;
    daddr = '0; dwdata = '0; prdata = '0; presp = 1'b0;

    // Reset state
    nxt();
    chk_en = 1'b1;
    neg();
    check("rst_rd",    pread,  1'b0);
    check("rst_wr",    pwrite, 1'b0);
    check("rst_iresp", iresp,  1'b0);
    check("rst_dresp", dresp,  1'b0);

    // I-only read of 0x1234
    nxt(); reset = 1'b0; ireq = 1'b1; iaddr = 16'h1234;
    neg(); check("i_idle_rd", pread, 1'b0);
    nxt();
    neg(); check("i_rd", pread, 1'b1); check("i_addr", paddr, 16'h1230);
    nxt(); nxt();
    nxt(); presp = 1'b1; line_v = {4{$urandom}}; prdata = line_v;
    neg(); check("i_resp", iresp, 1'b1); check("i_dresp0", dresp, 1'b0);
    check("i_rdata", irdata, line_v);
    nxt(); presp = 1'b0; ireq = 1'b0;
    neg(); check("i_done_rd", pread, 1'b0);

    // D writeback to 0x4008
    nxt(); dw = 1'b1; daddr = 16'h4008; dwdata = {16{8'hA5}};
    nxt();
    neg(); check("d_wr", pwrite, 1'b1); check("d_rd0", pread, 1'b0);
    check("d_addr", paddr, 16'h4000); check("d_wdata", pwdata, {16{8'hA5}});
    nxt(); presp = 1'b1;
    neg(); check("d_resp", dresp, 1'b1); check("d_iresp0", iresp, 1'b0);
    nxt(); presp = 1'b0; dw = 1'b0;

    // Tie with last grant = D
    nxt(); ireq = 1'b1; iaddr = 16'h0100; dr = 1'b1; daddr = 16'h2000;
    nxt();
    neg(); check("tie_first_addr", paddr, RR ? 16'h0100 : 16'h2000);
    check("tie_first_rd", pread, 1'b1);
    nxt(); presp = 1'b1;
    neg(); check("tie_first_iresp", iresp, RR); check("tie_first_dresp", dresp, !RR);
    nxt(); presp = 1'b0;
    if (RR) ireq = 1'b0; else dr = 1'b0;
    neg(); check("tie_gap_rd", pread, 1'b0);
    nxt();
    neg(); check("tie_second_addr", paddr, RR ? 16'h2000 : 16'h0100);
    check("tie_second_rd", pread, 1'b1);
    nxt(); presp = 1'b1;
    neg(); check("tie_second_iresp", iresp, !RR); check("tie_second_dresp", dresp, RR);
    nxt(); presp = 1'b0; ireq = 1'b0; dr = 1'b0;

    // D read and write together
    nxt(); dr = 1'b1; dw = 1'b1; daddr = 16'h3000;
    nxt();
    neg(); check("rw_wr", pwrite, 1'b1); check("rw_rd", pread, 1'b0);
    nxt(); presp = 1'b1;
    nxt(); presp = 1'b0; dr = 1'b0; dw = 1'b0;

    // Reset while serving D, late memory response
    nxt(); dr = 1'b1; daddr = 16'h5550;
    nxt();
    neg(); check("rst_mid_rd", pread, 1'b1);
    nxt(); reset = 1'b1; dr = 1'b0;
    nxt(); reset = 1'b0;
    nxt(); presp = 1'b1;
    neg(); check("rst_late_dresp", dresp, 1'b0); check("rst_late_iresp", iresp, 1'b0);
    check("rst_late_rd", pread, 1'b0); check("rst_late_wr", pwrite, 1'b0);
    nxt(); presp = 1'b0;

    // Randomized cache and memory agents
    i_got = 1'b0; d_got = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      nxt();
      if (i_got) ireq = 1'b0;
      else if (ireq && $urandom_range(0, 49) == 0) ireq = 1'b0;
      else if (!ireq && $urandom_range(0, 2) == 0) begin
        ireq = 1'b1; iaddr = 16'($urandom);
      end
      if (d_got) begin dr = 1'b0; dw = 1'b0; end
      else if ((dr || dw) && $urandom_range(0, 49) == 0) begin dr = 1'b0; dw = 1'b0; end
      else if (!(dr || dw) && $urandom_range(0, 2) == 0) begin
        kind = $urandom_range(0, 2);
        dr = (kind != 1); dw = (kind != 0);
        daddr = 16'($urandom); dwdata = {4{$urandom}};
      end
      presp  = ($urandom_range(0, 3) == 0);
      prdata = {4{$urandom}};
      reset  = ($urandom_range(0, 149) == 0);
      if (reset) begin ireq = 1'b0; dr = 1'b0; dw = 1'b0; end
      neg();
      i_got = iresp;
      d_got = dresp;
    end

    nxt(); reset = 1'b0; ireq = 1'b0; dr = 1'b0; dw = 1'b0; presp = 1'b0;
    neg();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
